wptr_full_gen: RTL
==================

# wptr_full_gen

Write-side pointer and full-flag generator for the asynchronous FIFO: the transmitting end of the Gray-pointer crossing. It owns the write-domain binary counter, produces the registered Gray write pointer that the read-domain two-flop synchronizer samples, and computes `wfull` from the read pointer already synchronized into the write domain. It sits between the write client and the FIFO memory, and drives memory address and write enable.

## Interface
- `ADDRSIZE`, 4: memory address width; FIFO depth = 2^ADDRSIZE; legal range ≥ 2.
- `AFULL_THRESH`, 2: almost-full margin in entries; used only when `WPTR_ALMOST_FULL_EN` is defined; legal range 1..2^ADDRSIZE−1.

Ports (clock `clk`; reset `rst_n`, asynchronous, active-low):
- `clk` input 1: write-domain clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `winc` input 1: write request from the client.
- `wq2_rptr` input ADDRSIZE+1: Gray read pointer, already synchronized into `clk`.
- `wptr` output ADDRSIZE+1: registered Gray write pointer, sent to the read-domain synchronizer.
- `waddr` output ADDRSIZE: memory write address; low bits of the binary pointer.
- `wen` output 1: memory write enable; `winc & ~wfull`; combinational.
- `wfull` output 1: registered full flag.
- `wovf` output 1: sticky overflow flag; set when `winc` is presented while `wfull` is high.
- `walmost_full` output 1: registered almost-full flag; present only with the macro.

## Operation
- State is a binary pointer `wbin[ADDRSIZE:0]` and its Gray image `wptr`, both registered.
- `wbinnext = wbin + wen`, modulo 2^(ADDRSIZE+1); the natural wrap is required.
- `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- On every edge: `wbin <= wbinnext`, `wptr <= wgraynext`.
- `waddr = wbin[ADDRSIZE-1:0]`.
- Full test: `wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]})`.
- `wptr` changes by at most one bit per cycle. It is a flop output with no combinational logic after the register, so the far end may sample it safely.
- Write while full: `wen` = 0, the pointer holds, and `wovf` is set. `wovf` is cleared only by reset.
- Full is pessimistic. `wq2_rptr` lags the read side by two or more write clocks, so `wfull` may stay high after space frees up. It never deasserts early.
- Simultaneous events: a `winc` in the same cycle that `wq2_rptr` advances is evaluated against the current `wfull`. If `wfull` is 1, the write is rejected that cycle, and `wfull` recomputes on that edge.

## Timing
- Reset values: `wbin` = 0, `wptr` = 0, `wfull` = 0, `wovf` = 0, `walmost_full` = 0.
  - `waddr` = 0 and `wen` = 0 for as long as `winc` = 0.
- Assertion of `rst_n` at any point clears all state asynchronously. Operation resumes on the first edge after deassertion.
- Accepted write: `waddr` and `wen` are valid in the request cycle. `wptr` and `waddr` advance on that edge.
- `wfull` asserts on the same edge that accepts the write filling the last slot. There is no extra cycle of latency.
- `wfull` deasserts on the first edge after `wq2_rptr` shows space.

## Configuration
- `WPTR_ALMOST_FULL_EN` defined:
  - `walmost_full` port and logic are present.
  - Compute `wlevel = wbinnext − gray2bin(wq2_rptr)`, modulo 2^(ADDRSIZE+1).
  - `walmost_full <= (wlevel >= 2^ADDRSIZE − AFULL_THRESH)`.
- `WPTR_ALMOST_FULL_EN` undefined: no `walmost_full` port, no Gray-to-binary logic, and `AFULL_THRESH` is ignored.

## Structure
- Shared FIFO package holds:
  - the `bin2gray`/`gray2bin` functions;
  - the depth constant derivation from `ADDRSIZE`;
  - the full-compare helper, shared with the read-side empty generator.
- One sub-module, `gray2bin_conv`: a combinational ADDRSIZE+1-wide Gray-to-binary XOR chain. It is instantiated only under the macro.

## Test plan
All scenarios use `ADDRSIZE` = 4 (depth 16).
- Reset: hold `rst_n` low with `winc` = 1 → `wptr` = 5'b00000, `wfull` = 0, `wovf` = 0, `waddr` = 0.
- Fill: `wq2_rptr` = 0, 16 consecutive `winc` → `waddr` steps 0..15; `wfull` rises on the 16th edge; `wptr` = 5'b11000.
- Overflow: while full, pulse `winc` → `wen` = 0, `wptr` stays 5'b11000, `wovf` = 1 and remains 1.
- Wrap: set `wq2_rptr` = 5'b11000, then 16 more writes → `wfull` clears one edge after the update and re-asserts with `wbin` = 0, `wptr` = 5'b00000.
- Simultaneous: while full, change `wq2_rptr` from 0 to 5'b00001 in the same cycle as `winc` → write rejected, `wfull` = 0 next cycle, the following `winc` is accepted with `waddr` = 0.
- Macro on, `AFULL_THRESH` = 2, `wq2_rptr` = 0: 14 writes → `walmost_full` rises on the 14th edge and `wfull` stays 0. Asserting `rst_n` mid-fill clears both flags immediately.

Source files
------------

// File: rtl/wptr_full_gen_pkg.sv
// ----------------------------------------------------------------------------
// wptr_full_gen_pkg
// Shared async-FIFO helpers used by both pointer generators:
//   - fifo_depth      : depth derived from the address width
//   - bin2gray        : binary -> Gray
//   - gray2bin        : Gray -> binary
//   - gray_full_match : Gray "full" compare (MSB and MSB-1 inverted)
// The functions work on a fixed maximum width. Callers zero-extend their
// pointers into ptr_max_t and truncate the result. Zero upper bits do not
// change the lower bits of either Gray conversion.
// ----------------------------------------------------------------------------
package wptr_full_gen_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Two Gray pointers that are exactly one depth apart differ only in
    // their two top bits. All lower bits are equal.
    function automatic logic gray_full_match(input ptr_max_t gray_local,
                                             input ptr_max_t gray_remote,
                                             input int       addrsize);
        ptr_max_t top_two_mask;
        top_two_mask = ptr_max_t'(3) << (addrsize - 1);
        return gray_local == (gray_remote ^ top_two_mask);
    endfunction

endpackage

// File: rtl/wptr_full_gen_if.sv
// ----------------------------------------------------------------------------
// wptr_full_gen_if
// Write-side bundle of the async FIFO.
//   winc         : write request from the client
//   wq2_rptr     : Gray read pointer, already synchronized into the write clock
//   wptr         : registered Gray write pointer, sent to the read-domain sync
//   waddr        : memory write address
//   wen          : memory write enable
//   wfull        : registered full flag
//   wovf         : sticky overflow flag
//   walmost_full : registered almost-full flag (only with WPTR_ALMOST_FULL_EN)
// Modports:
//   master : the write-side environment (client + synchronizer)
//   slave  : the pointer/flag generator
// ----------------------------------------------------------------------------
interface wptr_full_gen_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wen;
    logic                wfull;
    logic                wovf;
`ifdef WPTR_ALMOST_FULL_EN
    logic                walmost_full;
`endif

    modport master (
        output winc, wq2_rptr,
        input  wptr, waddr, wen, wfull, wovf
`ifdef WPTR_ALMOST_FULL_EN
        , input walmost_full
`endif
    );

    modport slave (
        input  winc, wq2_rptr,
        output wptr, waddr, wen, wfull, wovf
`ifdef WPTR_ALMOST_FULL_EN
        , output walmost_full
`endif
    );

endinterface

// File: rtl/wptr_full_gen_gray2bin_conv.sv
// ----------------------------------------------------------------------------
// gray2bin_conv
// Combinational Gray-to-binary converter of parameterizable width.
// Each binary bit is the XOR of all Gray bits at or above it.
//   i_gray : Gray-coded input
//   o_bin  : binary output
// ----------------------------------------------------------------------------
module gray2bin_conv #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/wptr_full_gen.sv
// ----------------------------------------------------------------------------
// wptr_full_gen
// Write-side pointer and full-flag generator for the asynchronous FIFO.
// It owns the binary write counter and the registered Gray write pointer.
// It also computes the full flag from the synchronized read pointer.
// Optional feature macro: WPTR_ALMOST_FULL_EN adds the walmost_full output.
// The add-on is a registered "level >= depth - AFULL_THRESH" flag.
// Ports:
//   clk   : write-domain clock
//   rst_n : asynchronous active-low reset
//   bus   : wptr_full_gen_if.slave (winc, wq2_rptr in; wptr, waddr, wen,
//           wfull, wovf[, walmost_full] out)
// ----------------------------------------------------------------------------
module wptr_full_gen
    import wptr_full_gen_pkg::*;
#(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    wptr_full_gen_if.slave  bus
);

    localparam int PTR_W = ADDRSIZE + 1;
    localparam int DEPTH = fifo_depth(ADDRSIZE);

    // Elaboration-time guard on the parameter ranges.
    if (ADDRSIZE < 2) begin : g_bad_addrsize
        $error("wptr_full_gen: ADDRSIZE must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_thresh
        $error("wptr_full_gen: AFULL_THRESH must be in 1..DEPTH-1");
    end

    logic [PTR_W-1:0] r_wbin;
    logic [PTR_W-1:0] r_wptr;
    logic             r_wfull;
    logic             r_wovf;

    logic             w_wen;
    logic [PTR_W-1:0] w_wbinnext;
    logic [PTR_W-1:0] w_wgraynext;
    logic             w_full_next;

    // A write that arrives while full is dropped. The pointer then holds.
    assign w_wen       = bus.winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + PTR_W'(w_wen);   // natural modulo-2^PTR_W wrap
    assign w_wgraynext = PTR_W'(bin2gray(ptr_max_t'(w_wbinnext)));

    // The compare uses the next pointer, so full rises on the same edge that
    // accepts the last write.
    assign w_full_next = gray_full_match(ptr_max_t'(w_wgraynext),
                                         ptr_max_t'(bus.wq2_rptr), ADDRSIZE);

    // NOTE: sequential state uses non-blocking assignments. All flops then
    // sample the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
            r_wovf  <= 1'b0;
        end else begin
            r_wbin  <= w_wbinnext;
            r_wptr  <= w_wgraynext;
            r_wfull <= w_full_next;
            if (bus.winc && r_wfull) begin
                r_wovf <= 1'b1;
            end
        end
    end

    // wptr comes straight from a flop, so the far domain never sees a glitch.
    assign bus.wptr  = r_wptr;
    assign bus.waddr = r_wbin[ADDRSIZE-1:0];
    assign bus.wen   = w_wen;
    assign bus.wfull = r_wfull;
    assign bus.wovf  = r_wovf;

`ifdef WPTR_ALMOST_FULL_EN
    localparam logic [PTR_W-1:0] AFULL_LEVEL = PTR_W'(DEPTH - AFULL_THRESH);

    logic [PTR_W-1:0] w_rbin;
    logic [PTR_W-1:0] w_wlevel;
    logic             r_walmost_full;

    gray2bin_conv #(
        .WIDTH (PTR_W)
    ) u_rptr_g2b (
        .i_gray (bus.wq2_rptr),
        .o_bin  (w_rbin)
    );

    // Occupancy seen from the write side. It is pessimistic, like full,
    // because the read pointer lags.
    assign w_wlevel = w_wbinnext - w_rbin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_walmost_full <= 1'b0;
        end else begin
            r_walmost_full <= (w_wlevel >= AFULL_LEVEL);
        end
    end

    assign bus.walmost_full = r_walmost_full;
`endif

endmodule
